mult_div_unit: RTL and testbench

//  Execute-stage HI/LO multiply/divide unit. It is driven by the decoder's start strobe and carries MULT/MULTU/DIV/DIVU/MTHI/MTLO.

---
 rtl/mult_div_unit_pkg.sv | 32 +++
 rtl/mult_div_unit_alu.sv | 58 +++++
 rtl/mult_div_unit.sv | 96 +++++++++
 tb/tb_mult_div_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared types and opcode encodings for the HI/LO multiply/divide unit.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // val is {hi, lo}; wr_en is cleared for a divide by zero so HI/LO are left alone.
    typedef struct packed {
        logic [63:0] val;
        logic        wr_en;
    } md_result_t;

    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/mult_div_unit_alu.sv
// Combinational 32x32 multiply and divide datapath producing a {hi, lo} result.
module mult_div_unit_alu
    import mult_div_unit_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output md_result_t  res_o
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               div_signed;
    logic               a_neg;
    logic               b_neg;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [31:0]        b_safe;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;
    logic [31:0]        quo;
    logic [31:0]        rem;

    assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign prod_u = {32'd0, a_i} * {32'd0, b_i};

    // Divide on magnitudes, then restore signs; -2^31 / -1 wraps naturally to 0x80000000.
    assign div_signed = (op_i == MD_DIV);
    assign a_neg      = div_signed & a_i[31];
    assign b_neg      = div_signed & b_i[31];
    assign a_mag      = a_neg ? (32'd0 - a_i) : a_i;
    assign b_mag      = b_neg ? (32'd0 - b_i) : b_i;
    assign b_safe     = (b_i == 32'd0) ? 32'd1 : b_mag;
    assign q_mag      = a_mag / b_safe;
    assign r_mag      = a_mag % b_safe;
    assign quo        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        res_o = '0;
        case (op_i)
            MD_MULT: begin
                res_o.val   = prod_s;
                res_o.wr_en = 1'b1;
            end
            MD_MULTU: begin
                res_o.val   = prod_u;
                res_o.wr_en = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                res_o.val   = {rem, quo};
                res_o.wr_en = (b_i != 32'd0);
            end
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage HI/LO unit: fixed-latency MULT/DIV with busy export, plus MTHI/MTLO.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        mt_en_i,
    input  logic [2:0]  md_op_i,
    input  logic        flush_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] rt_val_i,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    md_result_t         res_q, res_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    md_result_t         alu_res;

    mult_div_unit_alu u_alu (
        .op_i  (md_op_i),
        .a_i   (rs_val_i),
        .b_i   (rt_val_i),
        .res_o (alu_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MD_IDLE: begin
                // A flush kills whatever is in E this cycle; start wins over mt_en.
                if (!flush_i) begin
                    if (start_i) begin
                        if (is_arith_op(md_op_i)) begin
                            state_d = MD_BUSY;
                            cnt_d   = is_mult_op(md_op_i) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                            res_d   = alu_res;
                        end
                    end else if (mt_en_i) begin
                        if (md_op_i == MD_MTHI) begin
                            hi_d = rs_val_i;
                        end else if (md_op_i == MD_MTLO) begin
                            lo_d = rs_val_i;
                        end
                    end
                end
            end
            MD_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = MD_IDLE;
                    if (res_q.wr_en) begin
                        {hi_d, lo_d} = res_q.val;
                    end
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    assign busy_o = (state_q == MD_BUSY);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        mt_en_i = 1'b0;
    logic [2:0]  md_op_i = 3'd0;
    logic        flush_i = 1'b0;
    logic [31:0] rs_val_i = 32'd0;
    logic [31:0] rt_val_i = 32'd0;
    logic        busy_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .mt_en_i  (mt_en_i),
        .md_op_i  (md_op_i),
        .flush_i  (flush_i),
        .rs_val_i (rs_val_i),
        .rt_val_i (rt_val_i),
        .busy_o   (busy_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    always #5 clk = ~clk;

    // The hazard unit never issues into a busy unit; this bench must not either.
    always @(posedge clk) begin
        if (rst_n && busy_o && (start_i || mt_en_i))
            $error("bench issued an operation while busy");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = 64'(sa * sb); exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd2: if (b != 32'd0) begin
                      p = 64'(sa / sb); exp_lo = p[31:0];
                      p = 64'(sa % sb); exp_hi = p[31:0];
                  end
            3'd3: if (b != 32'd0) begin exp_lo = a / b; exp_hi = a % b; end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit flush_mid, input string tag);
        int n;
        int bad;
        int expn;
        n = 0;
        bad = 0;
        expn = (op <= 3'd1) ? MC : DC;
        @(negedge clk);
        start_i = 1'b1; md_op_i = op; rs_val_i = a; rt_val_i = b;
        @(negedge clk);
        start_i = 1'b0; rs_val_i = $urandom; rt_val_i = $urandom;
        while (busy_o && n < 100) begin
            n++;
            if (hi_o !== exp_hi || lo_o !== exp_lo) bad++;
            flush_i = (flush_mid && n == 2);
            @(negedge clk);
        end
        flush_i = 1'b0;
        model_op(op, a, b);
        check_val({tag, ".busy_cycles"}, 64'(n), 64'(expn));
        check_val({tag, ".hilo_stable"}, 64'(bad), 64'd0);
        check_val({tag, ".hi"}, {32'd0, hi_o}, {32'd0, exp_hi});
        check_val({tag, ".lo"}, {32'd0, lo_o}, {32'd0, exp_lo});
        $display("op=%0d rs=%h rt=%h flush_mid=%0d -> busy %0d hi=%h lo=%h", op, a, b, flush_mid, n, hi_o, lo_o);
    endtask

    task automatic run_mt(input logic [2:0] op, input logic [31:0] a, input bit fl, input string tag);
        @(negedge clk);
        mt_en_i = 1'b1; md_op_i = op; rs_val_i = a; flush_i = fl;
        @(negedge clk);
        mt_en_i = 1'b0; flush_i = 1'b0;
        if (!fl) model_op(op, a, 32'd0);
        check_val({tag, ".busy"}, {63'd0, busy_o}, 64'd0);
        check_val({tag, ".hi"}, {32'd0, hi_o}, {32'd0, exp_hi});
        check_val({tag, ".lo"}, {32'd0, lo_o}, {32'd0, exp_lo});
        $display("mt op=%0d rs=%h flush=%0d -> hi=%h lo=%h", op, a, fl, hi_o, lo_o);
    endtask

    task automatic run_flushed_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input string tag);
        @(negedge clk);
        start_i = 1'b1; md_op_i = op; rs_val_i = a; rt_val_i = b; flush_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        check_val({tag, ".busy"}, {63'd0, busy_o}, 64'd0);
        @(negedge clk);
        check_val({tag, ".busy2"}, {63'd0, busy_o}, 64'd0);
        check_val({tag, ".hi"}, {32'd0, hi_o}, {32'd0, exp_hi});
        check_val({tag, ".lo"}, {32'd0, lo_o}, {32'd0, exp_lo});
        $display("flushed start op=%0d rs=%h rt=%h -> busy=%0d hi=%h lo=%h", op, a, b, busy_o, hi_o, lo_o);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        #2;
        check_val("reset.busy", {63'd0, busy_o}, 64'd0);
        check_val("reset.hi", {32'd0, hi_o}, 64'd0);
        check_val("reset.lo", {32'd0, lo_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg");
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
        run_op(MD_DIVU, 32'd100, 32'd7, 1'b0, "divu");
        run_mt(MD_MTHI, 32'h0000_1234, 1'b0, "mthi");
        run_op(MD_DIVU, 32'd5, 32'd0, 1'b0, "divu_zero");
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        run_flushed_start(MD_MULT, 32'd2, 32'd3, "flush_issue");
        run_mt(MD_MTLO, 32'hDEAD_BEEF, 1'b1, "mtlo_flush");
        run_op(MD_MULT, 32'd123, 32'hFFFF_FF00, 1'b1, "mult_flush_mid");

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        start_i = 1'b1; md_op_i = MD_DIV; rs_val_i = 32'd1000; rt_val_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midreset.busy", {63'd0, busy_o}, 64'd0);
        check_val("midreset.hi", {32'd0, hi_o}, 64'd0);
        check_val("midreset.lo", {32'd0, lo_o}, 64'd0);
        $display("reset mid-DIV -> busy=%0d hi=%h lo=%h", busy_o, hi_o, lo_o);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(MD_MULT, 32'd3, 32'd4, 1'b0, "mult_after_reset");

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 5));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            if (op >= 3'd4)
                run_mt(op, a, ($urandom_range(0, 7) == 0), "rand_mt");
            else if ($urandom_range(0, 9) == 0)
                run_flushed_start(op, a, b, "rand_flush");
            else
                run_op(op, a, b, ($urandom_range(0, 3) == 0), "rand_op");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
